// File: rtl/cond_issue_ctrl_pkg.sv
// Shared definitions for the conditional-issue controller: ARM condition codes,
// NZCV bit positions and the post-branch flush FSM state type.
package cond_issue_ctrl_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int unsigned NZCV_N = 3;
  localparam int unsigned NZCV_Z = 2;
  localparam int unsigned NZCV_C = 1;
  localparam int unsigned NZCV_V = 0;

  typedef enum logic {
    FL_IDLE  = 1'b0,
    FL_FLUSH = 1'b1
  } flush_state_t;

  // Only AL ignores the flags; the reserved code still counts as dependent.
  function automatic logic cond_dep(input logic [3:0] cond);
    return cond != COND_AL;
  endfunction

endpackage

// File: rtl/cond_issue_ctrl_if.sv
// ID/EXE-side signal bundle of the conditional-issue controller.
// master = pipeline side driving ID/EXE info, slave = the controller.
interface cond_issue_ctrl_if #(
  parameter int unsigned PW = 2
);
  logic          id_valid;
  logic [3:0]    id_cond;
  logic          id_s;
  logic          exe_flag_we;
  logic [3:0]    exe_nzcv;
  logic          branch_taken;
  logic          id_stall;
  logic          id_exec;
  logic          id_kill;
  logic [3:0]    sr_nzcv;
  logic [PW-1:0] pending;
  logic          flush;

  modport master (
    output id_valid, id_cond, id_s, exe_flag_we, exe_nzcv, branch_taken,
    input  id_stall, id_exec, id_kill, sr_nzcv, pending, flush
  );

  modport slave (
    input  id_valid, id_cond, id_s, exe_flag_we, exe_nzcv, branch_taken,
    output id_stall, id_exec, id_kill, sr_nzcv, pending, flush
  );
endinterface

// File: rtl/cond_issue_ctrl_cond_eval.sv
// Combinational ARM condition-code evaluator: (cond, nzcv) -> condition true.
module cond_eval
  import cond_issue_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       cond_true
);

  logic n, z, c, v;

  assign n = nzcv[NZCV_N];
  assign z = nzcv[NZCV_Z];
  assign c = nzcv[NZCV_C];
  assign v = nzcv[NZCV_V];

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      COND_EQ: cond_true = z;
      COND_NE: cond_true = ~z;
      COND_CS: cond_true = c;
      COND_CC: cond_true = ~c;
      COND_MI: cond_true = n;
      COND_PL: cond_true = ~n;
      COND_VS: cond_true = v;
      COND_VC: cond_true = ~v;
      COND_HI: cond_true = c & ~z;
      COND_LS: cond_true = ~c | z;
      COND_GE: cond_true = (n == v);
      COND_LT: cond_true = (n != v);
      COND_GT: cond_true = ~z & (n == v);
      COND_LE: cond_true = z | (n != v);
      COND_AL: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_issue_ctrl.sv
// Conditional-issue controller: NZCV status register, flag-dependence stall,
// in-flight flag-writer tracking and post-branch flush. Optional macro FLAG_FWD_EN.
module cond_issue_ctrl
  import cond_issue_ctrl_pkg::*;
#(
  parameter int unsigned PIPE_DEPTH   = 2,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned PW           = $clog2(PIPE_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  cond_issue_ctrl_if.slave   bus
);

  localparam int unsigned   CW       = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYCLES - 1);

  flush_state_t  state;
  logic [CW-1:0] cnt;
  logic          flush_q;
  logic [3:0]    sr_q;
  logic [PW-1:0] pend_q;

  logic          dep;
  logic          fwd;
  logic [3:0]    eval_nzcv;
  logic          cond_true;
  logic          pend_full;
  logic          stall;
  logic          issue;
  logic          exec;
  logic          kill;
  logic          inc;
  logic          dec;

  assign dep       = cond_dep(bus.id_cond);
  assign pend_full = (pend_q == PW'(PIPE_DEPTH));

`ifdef FLAG_FWD_EN
  // The last outstanding writer lands this cycle: evaluate on its ALU flags.
  assign fwd       = (pend_q == PW'(1)) & bus.exe_flag_we;
  assign eval_nzcv = fwd ? bus.exe_nzcv : sr_q;
`else
  assign fwd       = 1'b0;
  assign eval_nzcv = sr_q;
`endif

  cond_eval u_cond_eval (
    .cond      (bus.id_cond),
    .nzcv      (eval_nzcv),
    .cond_true (cond_true)
  );

  always_comb begin
    stall = 1'b1;
    issue = 1'b0;
    exec  = 1'b0;
    kill  = 1'b0;
    if (!rst) begin
      stall = bus.id_valid & ~flush_q &
              ((dep & (pend_q != '0) & ~fwd) | (bus.id_s & pend_full));
      issue = bus.id_valid & ~stall;
      exec  = issue & ~flush_q & cond_true;
      kill  = issue & ~exec;
    end
  end

  assign inc = exec & bus.id_s;
  assign dec = bus.exe_flag_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q   <= '0;
      pend_q <= '0;
    end else begin
      if (bus.exe_flag_we) sr_q <= bus.exe_nzcv;
      if (inc && !dec) begin
        pend_q <= pend_q + 1'b1;
      end else if (dec && !inc && (pend_q != '0)) begin
        pend_q <= pend_q - 1'b1;
      end
    end
  end

  // flush_q mirrors state so the flush output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FL_IDLE;
      cnt     <= '0;
      flush_q <= 1'b0;
    end else begin
      case (state)
        FL_IDLE: begin
          if (bus.branch_taken) begin
            state   <= FL_FLUSH;
            cnt     <= CNT_LOAD;
            flush_q <= 1'b1;
          end
        end
        FL_FLUSH: begin
          if (bus.branch_taken) begin
            cnt <= CNT_LOAD;
          end else if (cnt == '0) begin
            state   <= FL_IDLE;
            flush_q <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state   <= FL_IDLE;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.id_stall = stall;
  assign bus.id_exec  = exec;
  assign bus.id_kill  = kill;
  assign bus.sr_nzcv  = sr_q;
  assign bus.pending  = pend_q;
  assign bus.flush    = flush_q;

endmodule

// File: tb/tb_cond_issue_ctrl.sv
// Scoreboard bench for cond_issue_ctrl: directed scenarios then random traffic,
// checked against a behavioural model of the issue rules.
module tb_cond_issue_ctrl;
  import cond_issue_ctrl_pkg::*;

  localparam int unsigned PD = 2;
  localparam int unsigned FC = 2;
  localparam int unsigned PW = $clog2(PD + 1);
`ifdef FLAG_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cond_issue_ctrl_if #(.PW(PW)) bus();

  cond_issue_ctrl #(
    .PIPE_DEPTH   (PD),
    .FLUSH_CYCLES (FC),
    .PW           (PW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit         stall;
    bit         exec;
    bit         kill;
    logic [3:0] sr;
    int         pend;
    bit         flush;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  logic [3:0] m_sr;
  int         m_pend;
  int         m_flush_left;

  // Codes 0..13 form complementary pairs: odd code = negation of the even one.
  function automatic bit cond_holds(input logic [3:0] code, input logic [3:0] f);
    bit n, z, c, v, base;
    logic [2:0] pair;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    if (code == 4'd15) return 1'b0;
    if (code == 4'd14) return 1'b1;
    pair = code[3:1];
    case (pair)
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c && !z;
      3'd5:    base = (n == v);
      default: base = !z && (n == v);
    endcase
    return code[0] ? !base : base;
  endfunction

  task automatic step(input bit r, input bit v, input logic [3:0] cond, input bit s,
                      input bit we, input logic [3:0] nz, input bit br);
    exp_t e;
    bit fl, dep, fwd, issue;
    logic [3:0] f;
    @(posedge clk);
    #1;
    rst              = r;
    bus.id_valid     = v;
    bus.id_cond      = cond;
    bus.id_s         = s;
    bus.exe_flag_we  = we;
    bus.exe_nzcv     = nz;
    bus.branch_taken = br;
    fl      = (m_flush_left > 0);
    e.sr    = m_sr;
    e.pend  = m_pend;
    e.flush = fl;
    if (r) begin
      e.stall = 1'b1; e.exec = 1'b0; e.kill = 1'b0;
    end else begin
      dep     = (cond != COND_AL);
      fwd     = FWD && (m_pend == 1) && we;
      f       = fwd ? nz : m_sr;
      e.stall = v && !fl && ((dep && m_pend > 0 && !fwd) || (s && m_pend == int'(PD)));
      issue   = v && !e.stall;
      e.exec  = issue && !fl && cond_holds(cond, f);
      e.kill  = issue && !e.exec;
    end
    sbq.push_back(e);
    if (r) begin
      m_sr = '0; m_pend = 0; m_flush_left = 0;
    end else begin
      if (we) m_sr = nz;
      m_pend = m_pend + ((e.exec && s) ? 1 : 0) - (we ? 1 : 0);
      if (m_pend < 0) m_pend = 0;
      if (br) m_flush_left = int'(FC);
      else if (m_flush_left > 0) m_flush_left--;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("id_stall", int'(bus.id_stall), int'(e.stall));
        chk("id_exec",  int'(bus.id_exec),  int'(e.exec));
        chk("id_kill",  int'(bus.id_kill),  int'(e.kill));
        chk("sr_nzcv",  int'(bus.sr_nzcv),  int'(e.sr));
        chk("pending",  int'(bus.pending),  e.pend);
        chk("flush",    int'(bus.flush),    int'(e.flush));
      end
    end
  end

  initial begin
    rst              = 1'b1;
    bus.id_valid     = 1'b0;
    bus.id_cond      = COND_AL;
    bus.id_s         = 1'b0;
    bus.exe_flag_we  = 1'b0;
    bus.exe_nzcv     = '0;
    bus.branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    m_sr = '0; m_pend = 0; m_flush_left = 0;

    // reset behaviour and first issue
    step(1, 1, COND_AL, 0, 0, 4'b0000, 0);
    step(0, 1, COND_AL, 0, 0, 4'b0000, 0);
    // flag write then EQ / NE
    step(0, 0, COND_AL, 0, 1, 4'b0100, 0);
    step(0, 1, COND_EQ, 0, 0, 4'b0000, 0);
    step(0, 1, COND_NE, 0, 0, 4'b0000, 0);
    // flag setter then dependent GT
    step(0, 1, COND_AL, 1, 0, 4'b0000, 0);
    step(0, 1, COND_GT, 0, 0, 4'b0000, 0);
    step(0, 1, COND_GT, 0, 0, 4'b0000, 0);
    step(0, 1, COND_GT, 0, 1, 4'b0000, 0);
    step(0, 1, COND_GT, 0, 0, 4'b0000, 0);
    // branch flush window, including a killed flag setter
    step(0, 0, COND_AL, 0, 0, 4'b0000, 1);
    step(0, 1, COND_AL, 1, 0, 4'b0000, 0);
    step(0, 1, COND_AL, 1, 0, 4'b0000, 0);
    step(0, 1, COND_AL, 0, 0, 4'b0000, 0);
    // pending saturation at PIPE_DEPTH and simultaneous inc/dec
    step(0, 1, COND_AL, 1, 0, 4'b0000, 0);
    step(0, 1, COND_AL, 1, 0, 4'b0000, 0);
    step(0, 1, COND_AL, 1, 0, 4'b0000, 0);
    step(0, 1, COND_AL, 1, 1, 4'b1010, 0);
    step(0, 1, COND_AL, 1, 1, 4'b0011, 0);
    step(0, 1, COND_AL, 1, 0, 4'b0000, 0);
    step(0, 1, COND_LT, 0, 1, 4'b1000, 0);
    step(0, 0, COND_AL, 0, 1, 4'b0001, 0);
    step(0, 0, COND_AL, 0, 1, 4'b0110, 0);
    // reset with pending outstanding, then reserved code
    step(0, 1, COND_AL, 1, 0, 4'b0000, 0);
    step(1, 1, COND_LE, 0, 0, 4'b0000, 0);
    step(0, 1, COND_NV, 0, 0, 4'b0000, 0);

    for (int i = 0; i < 4000; i++) begin
      bit r, v, s, we, br;
      logic [3:0] cond, nz;
      r    = ($urandom_range(0, 199) == 0);
      v    = ($urandom_range(0, 3) != 0);
      cond = ($urandom_range(0, 3) == 0) ? COND_AL : 4'($urandom_range(0, 15));
      s    = ($urandom_range(0, 1) != 0);
      we   = ($urandom_range(0, 2) == 0);
      nz   = 4'($urandom_range(0, 15));
      br   = ($urandom_range(0, 24) == 0);
      step(r, v, cond, s, we, nz, br);
    end

    step(0, 0, COND_AL, 0, 0, 4'b0000, 0);
    repeat (2) @(posedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
